// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM encoding and coordinate index constants for the sprite fetcher
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;
    localparam int NUM_COORDS = 6;
    localparam int IDX_MX  = 0;
    localparam int IDX_MY  = 1;
    localparam int IDX_P1X = 2;
    localparam int IDX_P1Y = 3;
    localparam int IDX_P2X = 4;
    localparam int IDX_P2Y = 5;
endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares the memory port between the sprite fetch and the CPU, tagging each read with its owner
module mem_port_arb #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_own,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_rvalid
);
    logic pend;
    logic owner_cpu;

    assign cpu_gnt      = cpu_req & ~fetch_own;
    assign mem_addr     = fetch_own ? fetch_addr : cpu_addr;
    assign mem_we       = cpu_gnt & cpu_we;
    assign mem_wdata    = cpu_wdata;
    assign cpu_rdata    = mem_rdata;
    assign cpu_rvalid   = pend & owner_cpu;
    assign fetch_rvalid = pend & ~owner_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= 1'b0;
            owner_cpu <= 1'b0;
        end else begin
            pend      <= fetch_own | (cpu_gnt & ~cpu_we);
            owner_cpu <= cpu_gnt;
        end
    end
endmodule

// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl: per-frame fetch of six sprite coordinates into shadows, committed atomically to the outputs
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mx,
    output logic [DATA_W-1:0] my,
    output logic [DATA_W-1:0] p1x,
    output logic [DATA_W-1:0] p1y,
    output logic [DATA_W-1:0] p2x,
    output logic [DATA_W-1:0] p2y,
    output logic              coords_valid,
    output logic              busy,
    output logic              overrun
);
    state_t            state;
    logic [2:0]        k;
    logic [2:0]        fetch_idx;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] shadow [NUM_COORDS];

    mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .clk          (clk),
        .reset        (reset),
        .fetch_own    (state == FETCH),
        .fetch_addr   (BASE_ADDR + ADDR_W'(k)),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .fetch_rvalid (fetch_rvalid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            fetch_idx    <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            coords_valid <= 1'b0;
            mx           <= '0;
            my           <= '0;
            p1x          <= '0;
            p1y          <= '0;
            p2x          <= '0;
            p2y          <= '0;
            for (int i = 0; i < NUM_COORDS; i++) shadow[i] <= '0;
        end else begin
            fetch_idx <= k;
            if (fetch_rvalid) shadow[fetch_idx] <= mem_rdata;
            if (frame && enable && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (frame && enable) begin
                    state <= FETCH;
                    k     <= '0;
                    busy  <= 1'b1;
                end
                FETCH: begin
                    k <= k + 3'd1;
                    if (k == 3'(NUM_COORDS - 1)) state <= DRAIN;
                end
                DRAIN: state <= COMMIT;
                COMMIT: begin
                    mx           <= shadow[IDX_MX];
                    my           <= shadow[IDX_MY];
                    p1x          <= shadow[IDX_P1X];
                    p1y          <= shadow[IDX_P1Y];
                    p2x          <= shadow[IDX_P2X];
                    p2y          <= shadow[IDX_P2Y];
                    coords_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// tb_sprite_fetch_ctrl: directed and random stimulus against a cycle-count reference model
module tb_sprite_fetch_ctrl;
    logic clk = 1'b0;
    logic reset, enable, frame, cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic cpu_gnt, cpu_rvalid, mem_we, coords_valid, busy, overrun;
    logic [15:0] mx, my, p1x, p1y, p2x, p2y;
    logic bd_we;
    logic [8:0] bd_addr;
    logic [15:0] bd_data;
    logic [15:0] mem [512];
    int checks = 0;
    int errors = 0;
    int rem = 0;
    logic [15:0] m_c [6];
    logic [15:0] m_pend [6];
    logic m_cv = 1'b0, m_ov = 1'b0, m_rv = 1'b0;
    logic [15:0] m_rd = '0;
    logic [15:0] got_c [6];

    always #5 clk = ~clk;

    sprite_fetch_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .frame(frame),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
        .coords_valid(coords_valid), .busy(busy), .overrun(overrun)
    );

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[8:0]];
        if (mem_we) mem[mem_addr[8:0]] <= mem_wdata;
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check combinational arbitration, clock, advance the model, check registered outputs.
    task cycle(input logic rst_i, en_i, fr_i, req_i, we_i, input logic [15:0] a_i, d_i,
               input logic bd_i, input logic [8:0] ba_i, input logic [15:0] bdd_i);
        logic rd_next, acc;
        logic [15:0] rd_val;
        reset = rst_i; enable = en_i; frame = fr_i; cpu_req = req_i; cpu_we = we_i;
        cpu_addr = a_i; cpu_wdata = d_i;
        bd_we = bd_i && rem < 3; bd_addr = ba_i; bd_data = bdd_i;
        #1;
        check("cpu_gnt", cpu_gnt, req_i && rem < 3);
        if (rem >= 3) begin
            check("fetch_addr", mem_addr, 16'h0100 + 16'(8 - rem));
            check("fetch_we", mem_we, 0);
        end else if (req_i) begin
            check("cpu_addr", mem_addr, a_i);
            check("cpu_we", mem_we, we_i);
        end else check("idle_we", mem_we, 0);
        rd_next = req_i && !we_i && rem < 3;
        rd_val = mem[a_i[8:0]];
        @(posedge clk);
        #1;
        if (rst_i) begin
            rem = 0; m_cv = 0; m_ov = 0; m_rv = 0;
            for (int i = 0; i < 6; i++) m_c[i] = '0;
        end else begin
            m_rv = rd_next; m_rd = rd_val;
            if (fr_i && en_i && rem != 0) m_ov = 1;
            acc = fr_i && en_i && rem == 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_c = m_pend;
                    m_cv = 1;
                end
            end
            if (acc) begin
                rem = 8;
                for (int i = 0; i < 6; i++) m_pend[i] = mem[9'(256 + i)];
            end
        end
        got_c = '{mx, my, p1x, p1y, p2x, p2y};
        for (int i = 0; i < 6; i++) check($sformatf("coord%0d", i), got_c[i], m_c[i]);
        check("coords_valid", coords_valid, m_cv);
        check("busy", busy, rem != 0);
        check("overrun", overrun, m_ov);
        check("cpu_rvalid", cpu_rvalid, m_rv);
        if (m_rv) check("cpu_rdata", cpu_rdata, m_rd);
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_c[i] = '0;
            m_pend[i] = '0;
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0, 0, 1, 9'(256 + i), 16'(10 * (i + 1)));
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 9'h005, 16'h1234);
        check("rst_busy", busy, 0);
        check("rst_valid", coords_valid, 0);
        idle(2);
        // Frame at T with CPU read of 0x0005 held throughout; second frame at T+3.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, i == 0 || i == 3, 1, 0, 16'h0005, 0, 0, 0, 0);
            if (i == 8) begin
                check("t9_mx", mx, 10);
                check("t9_my", my, 20);
                check("t9_p1x", p1x, 30);
                check("t9_p1y", p1y, 40);
                check("t9_p2x", p2x, 50);
                check("t9_p2y", p2y, 60);
                check("t9_busy", busy, 0);
                check("t9_overrun", overrun, 1);
            end
        end
        check("cpu_read5", cpu_rdata, 16'h1234);
        // Reset at T+4 discards the fetch.
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_mx", mx, 0);
        idle(10);
        check("no_commit", coords_valid, 0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        check("refetch_p2y", p2y, 60);
        // New memory contents; outputs hold until the next commit.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 0, 0, 1, 9'(256 + i), 16'(11 * (i + 1)));
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(7);
        check("hold_mx", mx, 10);
        idle(1);
        check("new_mx", mx, 11);
        check("new_p2y", p2y, 66);
        // Frame with enable low: nothing starts, CPU always granted.
        for (int i = 0; i < 6; i++) cycle(0, 0, i == 1, 1, i[0], 16'(i), 16'(i), 0, 0, 0);
        check("dis_overrun", overrun, 0);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 511)),
                  16'($urandom), $urandom_range(0, 7) == 0, 9'($urandom_range(256, 263)), 16'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_fetch_ctrl.md
SPRITE_FETCH_CTRL -- requirements
Module: sprite_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word and coordinate width.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0100, address of the first sprite-coordinate word.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: enable  in  1  fetch enable; frame  in  1  one-cycle start-of-frame pulse from VGA timing.
REQ-006 SHALL have ports: cpu_req  in  1  CPU access request; cpu_we  in  1  write; cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-007 SHALL have ports: cpu_gnt  out  1  request accepted this cycle; cpu_rvalid  out  1  cpu_rdata valid; cpu_rdata  out  DATA_W.
REQ-008 SHALL have ports: mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W, valid one cycle after the address is presented.
REQ-009 SHALL have ports: mx, my, p1x, p1y, p2x, p2y  out  DATA_W each  committed coordinates for monkey, platform 1 and platform 2.
REQ-010 SHALL have ports: coords_valid  out  1  at least one commit since reset; busy  out  1  fetch in progress; overrun  out  1  sticky missed-frame flag.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DRAIN, COMMIT.
REQ-012 IDLE: frame=1 and enable=1 -> FETCH next cycle, word index k=0; otherwise remain in IDLE.
REQ-013 FETCH: drive mem_addr=BASE_ADDR+k, mem_we=0; increment k each cycle; after k=5 is issued -> DRAIN.
REQ-014 DRAIN: capture the last returning word -> COMMIT; COMMIT: transfer all six shadow words to the outputs in one edge -> IDLE.
REQ-015 Word k returning one cycle after issue SHALL load shadow[k]; order is mx, my, p1x, p1y, p2x, p2y for k=0..5.
REQ-016 Outputs SHALL change only in COMMIT, all six on the same edge (no partially updated set); coords_valid set there.
REQ-017 Latency: frame accepted in cycle T -> addresses issued T+1..T+6, new outputs visible from T+9.
REQ-018 busy SHALL be 1 in FETCH, DRAIN and COMMIT, 0 in IDLE.
REQ-019 Arbitration: the fetch owns the memory port in FETCH; cpu_gnt SHALL be 0 in FETCH, otherwise equal to cpu_req (combinational).
REQ-020 In the cycle frame is accepted, a concurrent cpu_req SHALL still be granted; the fetch starts the next cycle.
REQ-021 On grant, mem_addr/mem_we/mem_wdata SHALL equal cpu_addr/cpu_we/cpu_wdata; when no one is granted, mem_we=0.
REQ-022 A granted CPU read SHALL assert cpu_rvalid for exactly one cycle, one cycle after grant, with cpu_rdata=mem_rdata; writes produce no cpu_rvalid.
REQ-023 A one-bit owner tag registered at issue SHALL route mem_rdata; fetch returns never assert cpu_rvalid.
REQ-024 frame=1 while busy=1 SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-025 frame with enable=0 SHALL be ignored without setting overrun; deasserting enable mid-fetch SHALL not abort it.
REQ-026 k SHALL be 3 bits; BASE_ADDR+k SHALL wrap modulo 2^ADDR_W.

Reset
REQ-027 On reset, state=IDLE, k=0, and all coordinate outputs, shadows, coords_valid, busy, overrun, cpu_rvalid, and the owner tag SHALL be 0.
REQ-028 Reset mid-fetch SHALL discard shadow contents; no commit occurs; outputs read 0 the next cycle.

Structure
REQ-029 FSM state encoding, NUM_COORDS=6 and coordinate index constants SHALL live in a shared package sprite_pkg.
REQ-030 The port arbiter/mux SHALL be one sub-module, mem_port_arb; the FSM and shadow registers stay in the top level.

Verification
REQ-031 Memory 0x100..0x105 = 10,20,30,40,50,60; frame pulse at T -> mx..p2y = 10..60 from T+9, coords_valid=1, busy=0 at T+9.
REQ-032 cpu_req held during fetch -> cpu_gnt=0 in T+1..T+6, granted at T+7; CPU read of 0x0005 returns its value with cpu_rvalid at T+8.
REQ-033 Second frame pulse at T+3 -> ignored, overrun=1, outputs still committed once at T+9.
REQ-034 Reset asserted at T+4 -> all outputs 0 at T+5, no commit follows; next frame fetches normally.
REQ-035 Memory changed to 11..66 between frames -> outputs hold 10..60 until the second commit, then all six switch on one edge.
REQ-036 enable=0 with frame pulse -> no fetch, busy=0, overrun=0, CPU granted every requested cycle.
